// File: rtl/svm_pkg.sv
// Shared definitions for the pixel stream source: default sizes and the
// FSM state encoding used by the producer side of the kernel interface.
package svm_pkg;

   localparam int XLEN_PIXEL_DEF     = 8;
   localparam int NUM_OF_PIXELS_DEF  = 784;
   localparam int NUM_OF_SV_DEF      = 10;
   localparam int KERNEL_LATENCY_DEF = 2;
   localparam int ADDR_W_DEF         = 10;

   // Running pixel sum width: 784 * 255 = 199920 fits in 18 bits.
   localparam int CHECKSUM_W = 18;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PRIME  = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DECIDE = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

endpackage

// File: rtl/pixel_stream_src_if.sv
// Stream bundle between the pixel source (master) and the kernel array /
// decision-function logic (slave). hold is the only backward signal.
interface pixel_stream_src_if
   import svm_pkg::*;
#(
   parameter int XLEN_PIXEL = XLEN_PIXEL_DEF,
   parameter int ADDR_W     = ADDR_W_DEF
);

   logic [XLEN_PIXEL-1:0] x_test;
   logic                  stall_MEM;
   logic [ADDR_W-1:0]     pixel_idx;
   logic                  decision_funct_en;
   logic                  hold;

   modport master (
      output x_test, stall_MEM, pixel_idx, decision_funct_en,
      input  hold
   );

   modport slave (
      input  x_test, stall_MEM, pixel_idx, decision_funct_en,
      output hold
   );

endinterface

// File: rtl/img_buf_ram.sv
// Image buffer: one write port, one registered read port with read enable.
// A write and a read to the same address in one cycle return the new data.
// The read register is cleared by reset; the array itself is not.
module img_buf_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 784
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data_p1;

   // Storage array write; contents survive reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered read with write-first bypass; holds value when re is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    rd_data_p1 <= '0;
      else if (re) rd_data_p1 <= (we && (waddr == raddr)) ? wdata : mem[raddr];
   end

   assign rdata = rd_data_p1;

endmodule

// File: rtl/pixel_stream_src.sv
// Pixel stream source: buffers one image from the host write port, streams it
// one pixel per cycle under downstream hold, waits for the kernel pipeline,
// opens the decision-function window and pulses done.
// Optional feature macro: STREAM_CHECKSUM_EN adds an 18-bit checksum output.
module pixel_stream_src
   import svm_pkg::*;
#(
   parameter int XLEN_PIXEL     = XLEN_PIXEL_DEF,
   parameter int NUM_OF_PIXELS  = NUM_OF_PIXELS_DEF,
   parameter int NUM_OF_SV      = NUM_OF_SV_DEF,
   parameter int KERNEL_LATENCY = KERNEL_LATENCY_DEF,
   parameter int ADDR_W         = ADDR_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [XLEN_PIXEL-1:0] wr_data,
   output logic                  wr_rej,
   input  logic                  en,
   output logic                  busy,
   output logic                  done,
`ifdef STREAM_CHECKSUM_EN
   output logic [CHECKSUM_W-1:0] checksum,
`endif
   pixel_stream_src_if.master    strm
);

   localparam int SEQ_MAX = (KERNEL_LATENCY > NUM_OF_SV) ? KERNEL_LATENCY : NUM_OF_SV;
   localparam int CNT_W   = $clog2(SEQ_MAX + 1);

   localparam logic [ADDR_W:0]    NPIX     = (ADDR_W+1)'(NUM_OF_PIXELS);
   localparam logic [ADDR_W-1:0]  LAST_PIX = ADDR_W'(NUM_OF_PIXELS - 1);
   localparam logic [CNT_W-1:0]   KL_LAST  = CNT_W'(KERNEL_LATENCY - 1);
   localparam logic [CNT_W-1:0]   SV_LAST  = CNT_W'(NUM_OF_SV - 1);

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     pix_cnt_q;
   logic [CNT_W-1:0]      seq_cnt_q;
   logic                  start, advance, stall, dfe;
   logic                  ram_re;
   logic [ADDR_W-1:0]     ram_raddr;
   logic [XLEN_PIXEL-1:0] ram_rdata;
   logic                  wr_acc;

   assign busy   = (state_q != ST_IDLE);
   assign wr_acc = wr_en && !busy && ({1'b0, wr_addr} < NPIX);

   img_buf_ram #(
      .DATA_W (XLEN_PIXEL),
      .ADDR_W (ADDR_W),
      .DEPTH  (NUM_OF_PIXELS)
   ) u_buf (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_acc),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   // Next-state, RAM read request and stream control outputs.
   always_comb begin
      state_d   = state_q;
      start     = 1'b0;
      advance   = 1'b0;
      ram_re    = 1'b0;
      ram_raddr = pix_cnt_q + 1'b1;
      stall     = 1'b1;
      dfe       = 1'b0;
      done      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ram_raddr = '0;
            if (en) begin
               start   = 1'b1;
               ram_re  = 1'b1;
               state_d = ST_PRIME;
            end
         end
         ST_PRIME: state_d = ST_STREAM;
         ST_STREAM: begin
            stall = strm.hold;
            if (!strm.hold) begin
               if (pix_cnt_q == LAST_PIX) begin
                  state_d = (KERNEL_LATENCY == 0) ? ST_DECIDE : ST_DRAIN;
               end else begin
                  // Fetch the next pixel so it lands on x_test next cycle.
                  advance = 1'b1;
                  ram_re  = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (seq_cnt_q == KL_LAST) state_d = ST_DECIDE;
         end
         ST_DECIDE: begin
            dfe = 1'b1;
            if (seq_cnt_q == SV_LAST) state_d = ST_DONE;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register; async reset aborts any run back to IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Pixel counter tracks the pixel on x_test; it never passes the last index.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         pix_cnt_q <= '0;
      else if (start)   pix_cnt_q <= '0;
      else if (advance) pix_cnt_q <= pix_cnt_q + 1'b1;
   end

   // Shared DRAIN/DECIDE cycle counter, restarted on every state change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                    seq_cnt_q <= '0;
      else if (state_d != state_q) seq_cnt_q <= '0;
      else if (state_q == ST_DRAIN || state_q == ST_DECIDE)
         seq_cnt_q <= seq_cnt_q + 1'b1;
   end

   // Dropped-write indication, one cycle after the rejected strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) wr_rej <= 1'b0;
      else      wr_rej <= wr_en && !wr_acc;
   end

`ifdef STREAM_CHECKSUM_EN
   // Sum of valid streamed pixels; cleared at start, frozen after STREAM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       checksum <= '0;
      else if (start) checksum <= '0;
      else if (state_q == ST_STREAM && !strm.hold)
         checksum <= checksum + CHECKSUM_W'(ram_rdata);
   end
`endif

   assign strm.x_test            = ram_rdata;
   assign strm.stall_MEM         = stall;
   assign strm.pixel_idx         = pix_cnt_q;
   assign strm.decision_funct_en = dfe;

endmodule

// File: tb/tb_pixel_stream_src.sv
// Bench for pixel_stream_src: a cycle-indexed reference model of the image
// stream (which pixel is expected next, when the decision window and done
// occur) checked against the DUT with immediate assertions.
module tb_pixel_stream_src;

   localparam int N   = 784;
   localparam int KL  = 2;
   localparam int NSV = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [9:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_rej;
   logic       en;
   logic       busy;
   logic       done;
`ifdef STREAM_CHECKSUM_EN
   logic [17:0] checksum;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] img [N];

   pixel_stream_src_if #(.XLEN_PIXEL(8), .ADDR_W(10)) sif ();

   pixel_stream_src dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_rej  (wr_rej),
      .en      (en),
      .busy    (busy),
      .done    (done),
`ifdef STREAM_CHECKSUM_EN
      .checksum(checksum),
`endif
      .strm    (sif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_stall"}, sif.stall_MEM, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_dfe"}, sif.decision_funct_en, 0);
      chk({tag, "_x_test"}, sif.x_test, 0);
      chk({tag, "_pixel_idx"}, sif.pixel_idx, 0);
      chk({tag, "_wr_rej"}, wr_rej, 0);
`ifdef STREAM_CHECKSUM_EN
      chk({tag, "_checksum"}, checksum, 0);
`endif
   endtask

   task automatic load_image();
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         wr_en = 1'b1; wr_addr = 10'(k); wr_data = img[k];
      end
      @(negedge clk);
      wr_en = 1'b0;
      #1;
      chk("load_rej", wr_rej, 0);
   endtask

   // hold_mode: 0 none, 1 three-cycle hold on pixel 100, 2 random hold.
   // abort_at >= 0 asserts reset while that pixel is valid.
   // wr_busy writes addr 5 = 0xAA mid-stream; en_dec pulses en inside DECIDE;
   // wr0_val >= 0 writes address 0 in the same cycle as en.
   task automatic run_image(input int hold_mode, input int abort_at, input int wr_busy,
                            input int en_dec, input int wr0_val,
                            output int done_cyc, output int n_hold);
      int nxt, last_valid, c, cur;
      logic [17:0] sum;
      nxt = 0; last_valid = -1; done_cyc = -1; n_hold = 0; sum = '0;
      // cycle 0: en sampled in IDLE
      @(negedge clk);
      en = 1'b1; sif.hold = 1'b0;
      if (wr0_val >= 0) begin
         wr_en = 1'b1; wr_addr = '0; wr_data = 8'(wr0_val); img[0] = 8'(wr0_val);
      end
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_stall", sif.stall_MEM, 1);
      // cycle 1: RAM latency
      @(negedge clk);
      en = 1'b0; wr_en = 1'b0;
      #1;
      chk("prime_busy", busy, 1);
      chk("prime_stall", sif.stall_MEM, 1);
      if (wr0_val >= 0) chk("wr0_rej", wr_rej, 0);
      for (c = 2; c < 3000 && done_cyc < 0; c++) begin
         @(negedge clk);
         sif.hold = 1'b0; en = 1'b0; wr_en = 1'b0;
         if (nxt < N) begin
            if (hold_mode == 1 && nxt == 100 && n_hold < 3) sif.hold = 1'b1;
            else if (hold_mode == 2) sif.hold = ($urandom_range(0, 3) == 0);
         end else if (hold_mode == 2) begin
            sif.hold = 1'($urandom_range(0, 1));
         end
         if (wr_busy != 0 && c == 50) begin
            wr_en = 1'b1; wr_addr = 10'd5; wr_data = 8'hAA;
         end
         if (en_dec != 0 && nxt == N && c == last_valid + KL + 3) en = 1'b1;
         #1;
         chk("busy", busy, 1);
         if (wr_busy != 0 && c == 51) chk("wr_busy_rej", wr_rej, 1);
         if (wr_busy != 0 && c == 52) chk("wr_busy_rej_end", wr_rej, 0);
         if (nxt < N) begin
            cur = nxt;
            chk("stream_stall", sif.stall_MEM, sif.hold);
            chk("x_test", sif.x_test, img[nxt]);
            chk("pixel_idx", sif.pixel_idx, nxt);
            chk("dfe_stream", sif.decision_funct_en, 0);
            if (sif.hold) n_hold++;
            else begin
               sum += 18'(img[nxt]);
               nxt++;
               if (nxt == N) last_valid = c;
            end
            if (abort_at >= 0 && cur == abort_at) begin
               #1 rst = 1'b0;
               #1;
               chk_reset("abort");
               return;
            end
         end else begin
            chk("post_stall", sif.stall_MEM, 1);
            chk("dfe", sif.decision_funct_en,
                32'((c > last_valid + KL) && (c <= last_valid + KL + NSV)));
            if (c == last_valid + KL + NSV + 1) begin
               chk("done", done, 1);
               done_cyc = c;
`ifdef STREAM_CHECKSUM_EN
               chk("checksum_model", checksum, sum);
`endif
            end else begin
               chk("done_early", done, 0);
            end
         end
      end
      @(negedge clk);
      #1;
      chk("busy_after_done", busy, 0);
      chk("done_single", done, 0);
      chk("idle_stall_after", sif.stall_MEM, 1);
   endtask

   initial begin
      int dc, nh;
      rst = 1'b0; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; sif.hold = 1'b0;
      @(negedge clk);
      #1;
      chk_reset("reset");
      @(negedge clk);
      rst = 1'b1;

      // Ramp image, free-running stream.
      for (int k = 0; k < N; k++) img[k] = 8'(k % 256);
      load_image();
      run_image(0, -1, 0, 0, -1, dc, nh);
      chk("latency_nohold", dc, 798);

      // Three-cycle hold while pixel 100 is presented.
      run_image(1, -1, 0, 0, -1, dc, nh);
      chk("hold_cycles", nh, 3);
      chk("latency_hold", dc, 801);

      // Write while busy is dropped; the next run still sees the old pixel 5.
      run_image(0, -1, 1, 0, -1, dc, nh);
      chk("latency_wr_busy", dc, 798);
      run_image(0, -1, 0, 0, -1, dc, nh);
      chk("latency_after_rej", dc, 798);

      // Out-of-range write in IDLE.
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 10'd784; wr_data = 8'h55;
      #1;
      chk("oor_idle", busy, 0);
      @(negedge clk);
      wr_en = 1'b0;
      #1;
      chk("oor_rej", wr_rej, 1);
      @(negedge clk);
      #1;
      chk("oor_rej_end", wr_rej, 0);

      // Reset while pixel 400 is valid: abort, no done, fresh start from 0.
      run_image(0, 400, 0, 0, -1, dc, nh);
      @(negedge clk);
      rst = 1'b1;
      repeat (20) begin
         @(negedge clk);
         #1;
         chk("abort_idle_busy", busy, 0);
         chk("abort_no_done", done, 0);
      end
      // Restart, with a stray en pulse inside DECIDE.
      run_image(0, -1, 0, 1, -1, dc, nh);
      chk("latency_en_decide", dc, 798);
      repeat (5) begin
         @(negedge clk);
         #1;
         chk("no_restart_busy", busy, 0);
      end

      // Random image, random hold, start with simultaneous write to address 0.
      for (int k = 0; k < N; k++) img[k] = 8'($urandom_range(0, 255));
      load_image();
      run_image(2, -1, 0, 0, int'($urandom_range(0, 255)), dc, nh);
      chk("latency_random", dc, 798 + nh);

`ifdef STREAM_CHECKSUM_EN
      for (int k = 0; k < N; k++) img[k] = 8'hFF;
      load_image();
      run_image(0, -1, 0, 0, -1, dc, nh);
      chk("checksum_ff", checksum, 199920);
      for (int k = 0; k < N; k++) img[k] = 8'h01;
      load_image();
      run_image(2, -1, 0, 0, -1, dc, nh);
      chk("checksum_01", checksum, 784);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
